mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters; MEM_ARB_TIMEOUT_EN enables BUSY timeout abort
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [63:0] f_addr,
   output logic        f_valid,
   output logic [79:0] f_rdata,
   output logic        f_error,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_valid,
   output logic [63:0] d_rdata,
   output logic        d_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [79:0] mem_rdata,
   input  logic        mem_ack,
   input  logic        mem_error
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state;
   logic owner_data;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] busy_cnt;
   logic f_win;
   logic timed_out;
   // fetch wins when alone or when it has lost STARVE_LIMIT times in a row
   always_comb begin
      f_win = f_req && (!d_req || starve_cnt == SW'(STARVE_LIMIT));
      timed_out = TO_EN && busy_cnt == TW'(TIMEOUT - 1);
   end
   // single FSM: grant in IDLE, drive memory in BUSY, one-cycle response pulse in RESP
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         starve_cnt <= '0;
         busy_cnt   <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         f_valid    <= 1'b0;
         f_rdata    <= '0;
         f_error    <= 1'b0;
         d_valid    <= 1'b0;
         d_rdata    <= '0;
         d_error    <= 1'b0;
      end else begin
         f_valid <= 1'b0;
         d_valid <= 1'b0;
         case (state)
            IDLE: if (f_req || d_req) begin
               state      <= BUSY;
               mem_req    <= 1'b1;
               busy_cnt   <= '0;
               owner_data <= !f_win;
               mem_addr   <= f_win ? f_addr : d_addr;
               mem_we     <= !f_win && d_write;
               mem_wdata  <= f_win ? '0 : d_wdata;
               starve_cnt <= f_win ? '0 :
                             (f_req && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
            end
            BUSY: if (mem_ack || timed_out) begin
               state   <= RESP;
               mem_req <= 1'b0;
               if (owner_data) begin
                  d_valid <= 1'b1;
                  d_error <= mem_ack ? mem_error : 1'b1;
                  if (mem_ack) d_rdata <= mem_rdata[63:0];
               end else begin
                  f_valid <= 1'b1;
                  f_error <= mem_ack ? mem_error : 1'b1;
                  if (mem_ack) f_rdata <= mem_rdata;
               end
            end else begin
               busy_cnt <= busy_cnt + TW'(busy_cnt != TW'(TIMEOUT - 1));
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model
module tb_mem_port_arbiter;
   localparam int STARVE  = 4;
   localparam int TIMEOUT = 15;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic        clock = 1'b0;
   logic        reset;
   logic        f_req, d_req, d_write, mem_ack, mem_error;
   logic [63:0] f_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata;
   logic [79:0] f_rdata, mem_rdata;
   logic        f_valid, f_error, d_valid, d_error, mem_req, mem_we;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        f, d, w;
      logic [63:0] fa, da, wd;
      logic        e_req, e_we;
      logic [63:0] e_addr;
      logic        e_fv, e_dv;
   } vec_t;
   vec_t vecs[6];

   always #5 clock = ~clock;

   mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_rdata(f_rdata), .f_error(f_error),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .d_error(d_error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_error(mem_error)
   );

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      f_req = 0; d_req = 0; d_write = 0; mem_ack = 0; mem_error = 0;
      f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1;
      cyc();
      reset = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_f_valid"}, f_valid, 0);
      chk({tag, "_d_valid"}, d_valid, 0);
      chk({tag, "_f_rdata"}, f_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_f_error"}, f_error, 0);
      chk({tag, "_d_error"}, d_error, 0);
   endtask

   // from an IDLE cycle with requests applied: sample the BUSY cycle, ack at once, sample the following cycle
   task automatic run_txn(input logic [79:0] rd, input logic er, output logic got_req, output logic we,
                          output logic [63:0] addr, output logic fv, output logic dv);
      cyc();
      got_req = mem_req; we = mem_we; addr = mem_addr;
      mem_ack = 1; mem_rdata = rd; mem_error = er;
      cyc();
      fv = f_valid; dv = d_valid;
      mem_ack = 0; mem_error = 0;
   endtask

   initial begin
      logic        g_req, g_we, g_fv, g_dv;
      logic [63:0] g_addr;
      logic [79:0] rd;
      int n, bad, fetch_at;
      int ph, starve, busy_cycles;
      bit own_d, m_we, fw, drd_known, e_fv, e_dv, e_fe, e_de;
      logic [63:0] m_addr, m_wd, e_drd;
      logic [79:0] e_frd;

      vecs[0] = '{1, 0, 0, 64'h40,  64'h0,   64'h0,  1, 0, 64'h40,  1, 0};
      vecs[1] = '{0, 1, 0, 64'h0,   64'h88,  64'h0,  1, 0, 64'h88,  0, 1};
      vecs[2] = '{0, 1, 1, 64'h0,   64'h90,  64'h77, 1, 1, 64'h90,  0, 1};
      vecs[3] = '{1, 1, 1, 64'h44,  64'h100, 64'h55, 1, 1, 64'h100, 0, 1};
      vecs[4] = '{1, 0, 1, 64'h48,  64'h98,  64'h66, 1, 0, 64'h48,  1, 0};
      vecs[5] = '{0, 0, 1, 64'h4c,  64'h9c,  64'h11, 0, 0, 64'h0,   0, 0};

      do_reset();
      chk_zero("reset");

      for (int i = 0; i < 6; i++) begin
         do_reset();
         f_req = vecs[i].f; d_req = vecs[i].d; d_write = vecs[i].w;
         f_addr = vecs[i].fa; d_addr = vecs[i].da; d_wdata = vecs[i].wd;
         rd = {16'($urandom), $urandom, $urandom};
         run_txn(rd, 0, g_req, g_we, g_addr, g_fv, g_dv);
         chk($sformatf("vec%0d_mem_req", i), g_req, vecs[i].e_req);
         if (vecs[i].e_req) begin
            chk($sformatf("vec%0d_mem_we", i), g_we, vecs[i].e_we);
            chk($sformatf("vec%0d_mem_addr", i), g_addr, vecs[i].e_addr);
         end
         chk($sformatf("vec%0d_f_valid", i), g_fv, vecs[i].e_fv);
         chk($sformatf("vec%0d_d_valid", i), g_dv, vecs[i].e_dv);
         if (vecs[i].e_fv) chk($sformatf("vec%0d_f_rdata", i), f_rdata, rd);
         if (vecs[i].e_dv && !vecs[i].e_we) chk($sformatf("vec%0d_d_rdata", i), d_rdata, {16'h0, rd[63:0]});
      end

      do_reset();
      f_req = 1; f_addr = 64'h40;
      cyc();
      chk("fetch_mem_req", mem_req, 1);
      chk("fetch_mem_addr", mem_addr, 64'h40);
      chk("fetch_mem_we", mem_we, 0);
      mem_ack = 1; mem_rdata = 80'h30F2_0A00000000000000;
      cyc();
      chk("fetch_f_valid", f_valid, 1);
      chk("fetch_f_rdata", f_rdata, 80'h30F2_0A00000000000000);
      chk("fetch_f_error", f_error, 0);
      chk("fetch_mem_req_drop", mem_req, 0);
      mem_ack = 0; f_req = 0; mem_rdata = '0;
      cyc();
      chk("fetch_pulse_once", f_valid, 0);
      chk("fetch_rdata_hold", f_rdata, 80'h30F2_0A00000000000000);

      do_reset();
      f_req = 1; d_req = 1; d_write = 1; d_addr = 64'h100; d_wdata = 64'h55; f_addr = 64'h40;
      cyc();
      chk("simul_we", mem_we, 1);
      chk("simul_addr", mem_addr, 64'h100);
      chk("simul_wdata", mem_wdata, 64'h55);
      mem_ack = 1;
      cyc();
      chk("simul_d_valid", d_valid, 1);
      chk("simul_f_valid0", f_valid, 0);
      mem_ack = 0; d_req = 0; d_write = 0;
      cyc();
      cyc();
      chk("simul_fetch_req", mem_req, 1);
      chk("simul_fetch_addr", mem_addr, 64'h40);
      chk("simul_fetch_we", mem_we, 0);
      mem_ack = 1; mem_rdata = 80'h1234;
      cyc();
      chk("simul_f_valid", f_valid, 1);
      mem_ack = 0; f_req = 0;
      cyc();

      do_reset();
      f_req = 1; f_addr = 64'h80; d_req = 1;
      fetch_at = -1;
      for (int i = 0; i < 5; i++) begin
         d_addr = 64'h200 + 64'(i);
         run_txn(80'(i), 0, g_req, g_we, g_addr, g_fv, g_dv);
         if (g_fv && fetch_at < 0) fetch_at = i;
         if (i == 3) chk("starve_saturated", dut.starve_cnt, STARVE);
         cyc();
      end
      chk("starve_fetch_grant_index", 80'(fetch_at), 4);
      chk("starve_cleared", dut.starve_cnt, 0);
      idle_in();
      cyc();

      do_reset();
      d_req = 1; d_addr = 64'h2000;
      cyc();
      chk("err_addr", mem_addr, 64'h2000);
      chk("err_we", mem_we, 0);
      mem_ack = 1; mem_error = 1;
      cyc();
      chk("err_d_valid", d_valid, 1);
      chk("err_d_error", d_error, 1);
      chk("err_f_valid", f_valid, 0);
      mem_ack = 0; mem_error = 0; d_req = 0;
      cyc();
      chk("err_d_valid_once", d_valid, 0);

      do_reset();
      d_req = 1; d_addr = 64'h3000;
      cyc();
      d_req = 0;
      if (TO_EN) begin
         n = 0;
         while (mem_req && n < 100) begin
            n++;
            cyc();
         end
         chk("timeout_busy_cycles", 80'(n), TIMEOUT);
         chk("timeout_d_valid", d_valid, 1);
         chk("timeout_d_error", d_error, 1);
         chk("timeout_d_rdata", d_rdata, 0);
         chk("timeout_mem_req", mem_req, 0);
      end else begin
         bad = 0;
         repeat (100) begin
            if (!mem_req || d_valid || f_valid) bad++;
            cyc();
         end
         chk("no_timeout_wait", 80'(bad), 0);
      end

      do_reset();
      d_req = 1; d_addr = 64'h4000;
      mem_ack = 1; mem_rdata = 80'hABCD;
      run_txn(80'hABCD, 0, g_req, g_we, g_addr, g_fv, g_dv);
      d_req = 1; d_addr = 64'h5000;
      cyc();
      cyc();
      chk("rst_mid_busy", mem_req, 1);
      cyc();
      reset = 1; d_req = 0;
      cyc();
      reset = 0;
      chk_zero("rst_mid");
      mem_ack = 1; mem_rdata = 80'hFFFF;
      cyc();
      mem_ack = 0;
      bad = 0;
      repeat (5) begin
         if (f_valid || d_valid || mem_req) bad++;
         cyc();
      end
      chk("rst_late_ack_ignored", 80'(bad), 0);
      f_req = 1; f_addr = 64'h6000;
      cyc();
      chk("rst_back_to_idle", mem_req, 1);
      chk("rst_back_addr", mem_addr, 64'h6000);
      f_req = 0;

      do_reset();
      ph = 0; starve = 0; busy_cycles = 0; own_d = 0; m_we = 0; m_addr = '0; m_wd = '0;
      e_frd = '0; e_drd = '0; drd_known = 1; e_fv = 0; e_dv = 0; e_fe = 0; e_de = 0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_mem_req", mem_req, ph == 1);
         if (ph == 1) begin
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_we", mem_we, m_we);
            if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wd);
         end
         chk("rnd_f_valid", f_valid, e_fv);
         chk("rnd_d_valid", d_valid, e_dv);
         if (e_fv) chk("rnd_f_error", f_error, e_fe);
         if (e_dv) chk("rnd_d_error", d_error, e_de);
         chk("rnd_f_rdata", f_rdata, e_frd);
         if (drd_known) chk("rnd_d_rdata", d_rdata, e_drd);
         f_req = $urandom_range(0, 3) != 0;
         d_req = $urandom_range(0, 1) != 0;
         d_write = $urandom_range(0, 1) != 0;
         f_addr = {$urandom, $urandom};
         d_addr = {$urandom, $urandom};
         d_wdata = {$urandom, $urandom};
         mem_ack = $urandom_range(0, 2) == 0;
         mem_error = $urandom_range(0, 3) == 0;
         mem_rdata = {16'($urandom), $urandom, $urandom};
         e_fv = 0; e_dv = 0;
         if (ph == 0) begin
            if (f_req || d_req) begin
               fw = f_req && (!d_req || starve >= STARVE);
               own_d = !fw;
               m_addr = fw ? f_addr : d_addr;
               m_we = !fw && d_write;
               m_wd = d_wdata;
               starve = fw ? 0 : (f_req ? ((starve + 1 > STARVE) ? STARVE : starve + 1) : starve);
               busy_cycles = 0;
               ph = 1;
            end
         end else if (ph == 1) begin
            busy_cycles++;
            if (mem_ack || (TO_EN && busy_cycles == TIMEOUT)) begin
               ph = 2;
               if (own_d) begin
                  e_dv = 1;
                  e_de = mem_ack ? mem_error : 1'b1;
                  if (mem_ack && m_we) drd_known = 0;
                  if (mem_ack && !m_we) begin
                     e_drd = mem_rdata[63:0];
                     drd_known = 1;
                  end
               end else begin
                  e_fv = 1;
                  e_fe = mem_ack ? mem_error : 1'b1;
                  if (mem_ack) e_frd = mem_rdata;
               end
            end
         end else begin
            ph = 0;
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
